// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access stage: op codes, FSM states and
// active-level constants for the external bus.
package mem_access_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDW  = 4'd1,
    OP_LDH  = 4'd2,
    OP_LDHU = 4'd3,
    OP_LDB  = 4'd4,
    OP_LDBU = 4'd5,
    OP_STW  = 4'd6,
    OP_STH  = 4'd7,
    OP_STB  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;
  localparam logic LANE_EN    = 1'b1;
  localparam logic LANE_DIS   = 1'b0;
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LDW) && (op <= OP_LDBU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: alignment check, store lane enables/replication and
// load lane extraction with sign or zero extension.
module mem_lane_align #(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int OFS_W  = $clog2(BE_W)
) (
  input  logic [3:0]        op,
  input  logic [OFS_W-1:0]  ofs,
  input  logic [DATA_W-1:0] st_data,
  input  logic [3:0]        ld_op,
  input  logic [OFS_W-1:0]  ld_ofs,
  input  logic [DATA_W-1:0] rd_data,
  output logic              is_mem,
  output logic              rd_wr,
  output logic              aligned,
  output logic [BE_W-1:0]   lane_en,
  output logic [DATA_W-1:0] lane_data,
  output logic [DATA_W-1:0] ld_data
);
  import mem_access_pkg::*;

  localparam logic [BE_W-1:0] BE_ONE = {{(BE_W-1){LANE_DIS}}, LANE_EN};
  localparam logic [BE_W-1:0] BE_TWO = {{(BE_W-2){LANE_DIS}}, LANE_EN, LANE_EN};

  logic [15:0] lane16;

  // Low 16 bits after shifting the addressed lane down to bit 0.
  assign lane16 = 16'(rd_data >> {ld_ofs, 3'b000});

  // Decode the incoming op into bus direction, lane enables and store data.
  always_comb begin
    is_mem    = 1'b1;
    rd_wr     = RW_READ;
    aligned   = 1'b1;
    lane_en   = {BE_W{LANE_EN}};
    lane_data = st_data;
    case (op)
      OP_LDW:           aligned = (ofs == {OFS_W{1'b0}});
      OP_LDH, OP_LDHU:  aligned = ~ofs[0];
      OP_LDB, OP_LDBU:  aligned = 1'b1;
      OP_STW: begin
        rd_wr   = RW_WRITE;
        aligned = (ofs == {OFS_W{1'b0}});
      end
      OP_STH: begin
        rd_wr     = RW_WRITE;
        aligned   = ~ofs[0];
        lane_en   = BE_TWO << ofs;
        lane_data = {(DATA_W/16){st_data[15:0]}};
      end
      OP_STB: begin
        rd_wr     = RW_WRITE;
        lane_en   = BE_ONE << ofs;
        lane_data = {BE_W{st_data[7:0]}};
      end
      default: begin
        is_mem  = 1'b0;
        lane_en = {BE_W{LANE_DIS}};
      end
    endcase
  end

  // Extract and extend the load result for the op held during the access.
  always_comb begin
    ld_data = {DATA_W{1'b0}};
    case (ld_op)
      OP_LDW:  ld_data = rd_data;
      OP_LDH:  ld_data = {{(DATA_W-16){lane16[15]}}, lane16};
      OP_LDHU: ld_data = {{(DATA_W-16){1'b0}}, lane16};
      OP_LDB:  ld_data = {{(DATA_W-8){lane16[7]}}, lane16[7:0]};
      OP_LDBU: ld_data = {{(DATA_W-8){1'b0}}, lane16[7:0]};
      default: ld_data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage bus master: issues one registered bus transfer per aligned memory
// op, waits for rdy_ with a timeout, and returns the MEM result on out.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int BE_W    = DATA_W / 8,
  parameter int OFS_W   = $clog2(BE_W),
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_en,
  input  logic [3:0]              ex_mem_op,
  input  logic [DATA_W-1:0]       ex_mem_wr_data,
  input  logic [DATA_W-1:0]       ex_out,
  input  logic [DATA_W-1:0]       rd_data,
  input  logic                    rdy_,
  output logic [DATA_W-OFS_W-1:0] addr,
  output logic                    as_,
  output logic                    rw,
  output logic [DATA_W-1:0]       wr_data,
  output logic [BE_W-1:0]         byte_en,
  output logic [DATA_W-1:0]       out,
  output logic                    stall,
  output logic                    miss_align,
  output logic                    bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int AW    = DATA_W - OFS_W;

  state_e             state_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic [3:0]         op_r;
  logic [OFS_W-1:0]   ofs_r;

  logic               is_mem_s;
  logic               rd_wr_s;
  logic               aligned_s;
  logic [BE_W-1:0]    lane_en_s;
  logic [DATA_W-1:0]  lane_data_s;
  logic [DATA_W-1:0]  ld_data_s;

  mem_lane_align #(
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .OFS_W  (OFS_W)
  ) u_align (
    .op        (ex_mem_op),
    .ofs       (ex_out[OFS_W-1:0]),
    .st_data   (ex_mem_wr_data),
    .ld_op     (op_r),
    .ld_ofs    (ofs_r),
    .rd_data   (rd_data),
    .is_mem    (is_mem_s),
    .rd_wr     (rd_wr_s),
    .aligned   (aligned_s),
    .lane_en   (lane_en_s),
    .lane_data (lane_data_s),
    .ld_data   (ld_data_s)
  );

  // Hold the pipeline from the accept cycle until the transfer leaves ACCESS.
  assign stall = (state_r == ST_ACCESS) ||
                 ((state_r == ST_IDLE) && ex_en && is_mem_s && aligned_s);

  // Transfer FSM with all bus and result outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {CNT_W{1'b0}};
      op_r       <= OP_NOP;
      ofs_r      <= {OFS_W{1'b0}};
      addr       <= {AW{1'b0}};
      as_        <= STROBE_OFF;
      rw         <= RW_READ;
      wr_data    <= {DATA_W{1'b0}};
      byte_en    <= {BE_W{LANE_DIS}};
      out        <= {DATA_W{1'b0}};
      miss_align <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      miss_align <= 1'b0;
      bus_err    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ex_en && is_mem_s) begin
            if (aligned_s) begin
              state_r    <= ST_ACCESS;
              wait_cnt_r <= {CNT_W{1'b0}};
              op_r       <= ex_mem_op;
              ofs_r      <= ex_out[OFS_W-1:0];
              addr       <= ex_out[DATA_W-1:OFS_W];
              as_        <= STROBE_ON;
              rw         <= rd_wr_s;
              wr_data    <= lane_data_s;
              byte_en    <= lane_en_s;
            end else begin
              out        <= {DATA_W{1'b0}};
              miss_align <= 1'b1;
            end
          end else if (ex_en) begin
            out <= ex_out;
          end else begin
            out <= {DATA_W{1'b0}};
          end
        end
        ST_ACCESS: begin
          if (!rdy_) begin
            state_r <= ST_DONE;
            as_     <= STROBE_OFF;
            byte_en <= {BE_W{LANE_DIS}};
            out     <= ld_data_s;
          end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
            state_r <= ST_DONE;
            as_     <= STROBE_OFF;
            byte_en <= {BE_W{LANE_DIS}};
            out     <= {DATA_W{1'b0}};
            bus_err <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (DATA_W=32, TIMEOUT=16).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, ex_en, rdy_;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data, ex_out, rd_data;
  logic [29:0] addr;
  logic        as_, rw;
  logic [31:0] wr_data, out;
  logic [3:0]  byte_en;
  logic        stall, miss_align, bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out), .rd_data(rd_data),
    .rdy_(rdy_), .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data),
    .byte_en(byte_en), .out(out), .stall(stall), .miss_align(miss_align),
    .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_en = 1'b0; ex_mem_op = 4'd0; ex_out = 32'h0;
    ex_mem_wr_data = 32'h0; rd_data = 32'h0; rdy_ = 1'b1;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (as_ !== 1'b1) begin errors++; $display("FAIL reset_as: got %b want 1", as_); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b want 1", rw); end
    checks++; if (addr !== 30'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (byte_en !== 4'h0) begin errors++; $display("FAIL reset_byte_en: got %h want 0", byte_en); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
    checks++; if ({miss_align, bus_err, stall} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {miss_align, bus_err, stall}); end
  endtask

  task automatic test_ldb();
    int stall_cnt = 0;
    ex_en = 1'b1; ex_mem_op = 4'd4; ex_out = 32'h103; rd_data = 32'h80FF_FF12; rdy_ = 1'b0;
    #1; if (stall === 1'b1) stall_cnt++;
    step();
    ex_en = 1'b0;
    #1; if (stall === 1'b1) stall_cnt++;
    checks++; if (as_ !== 1'b0) begin errors++; $display("FAIL ldb_as_low: got %b want 0", as_); end
    checks++; if (addr !== 30'h40) begin errors++; $display("FAIL ldb_addr: got %h want 40", addr); end
    checks++; if (byte_en !== 4'hF) begin errors++; $display("FAIL ldb_byte_en: got %h want f", byte_en); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL ldb_rw: got %b want 1", rw); end
    step();
    if (stall === 1'b1) stall_cnt++;
    checks++; if (as_ !== 1'b1) begin errors++; $display("FAIL ldb_as_release: got %b want 1", as_); end
    checks++; if (out !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_out: got %h want ffffff80", out); end
    checks++; if (byte_en !== 4'h0) begin errors++; $display("FAIL ldb_byte_en_off: got %h want 0", byte_en); end
    ex_en = 1'b1; ex_mem_op = 4'd0; ex_out = 32'h99; rdy_ = 1'b1;
    step();
    checks++; if (out !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_done_ignores_en: got %h want ffffff80", out); end
    checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL ldb_stall_cycles: got %0d want 2", stall_cnt); end
    step();
    checks++; if (out !== 32'h99) begin errors++; $display("FAIL ldb_next_nonmem: got %h want 99", out); end
    idle_in(); step();
  endtask

  task automatic test_sth_wait();
    ex_en = 1'b1; ex_mem_op = 4'd0; ex_out = 32'h5555_AAAA;
    step();
    ex_mem_op = 4'd7; ex_out = 32'h202; ex_mem_wr_data = 32'h1234_ABCD; rdy_ = 1'b1;
    step();
    ex_en = 1'b0;
    #1;
    checks++; if (addr !== 30'h80) begin errors++; $display("FAIL sth_addr: got %h want 80", addr); end
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL sth_rw: got %b want 0", rw); end
    checks++; if (byte_en !== 4'b1100) begin errors++; $display("FAIL sth_byte_en: got %b want 1100", byte_en); end
    checks++; if (wr_data !== 32'hABCD_ABCD) begin errors++; $display("FAIL sth_wr_data: got %h want abcdabcd", wr_data); end
    step(); step(); step();
    checks++; if ({as_, stall} !== 2'b01) begin errors++; $display("FAIL sth_waiting: got as_,stall=%b want 01", {as_, stall}); end
    rdy_ = 1'b0;
    step();
    rdy_ = 1'b1;
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL sth_out: got %h want 0", out); end
    checks++; if ({as_, stall} !== 2'b10) begin errors++; $display("FAIL sth_done: got as_,stall=%b want 10", {as_, stall}); end
    idle_in(); step();
  endtask

  task automatic test_misalign();
    int as_low = 0;
    ex_en = 1'b1; ex_mem_op = 4'd0; ex_out = 32'h77;
    step();
    ex_mem_op = 4'd1; ex_out = 32'h6;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b want 0", stall); end
    step();
    ex_mem_op = 4'd7; ex_out = 32'h1;
    if (as_ === 1'b0) as_low++;
    checks++; if (miss_align !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", miss_align); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL mis_out: got %h want 0", out); end
    step();
    ex_en = 1'b0;
    if (as_ === 1'b0) as_low++;
    checks++; if (miss_align !== 1'b1) begin errors++; $display("FAIL mis_sth_pulse: got %b want 1", miss_align); end
    step();
    if (as_ === 1'b0) as_low++;
    checks++; if (miss_align !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b want 0", miss_align); end
    checks++; if (as_low !== 0) begin errors++; $display("FAIL mis_no_bus: got %0d strobe cycles want 0", as_low); end
    idle_in();
  endtask

  task automatic test_timeout();
    int low = 0;
    int pulses = 0;
    logic [31:0] err_out = 32'hFFFF_FFFF;
    logic err_stall = 1'b1;
    ex_en = 1'b1; ex_mem_op = 4'd0; ex_out = 32'h1234;
    step();
    ex_mem_op = 4'd3; ex_out = 32'h10; rdy_ = 1'b1;
    step();
    ex_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (as_ === 1'b0) low++;
      if (bus_err === 1'b1) begin pulses++; err_out = out; err_stall = stall; end
      step();
    end
    checks++; if (low !== 16) begin errors++; $display("FAIL to_as_cycles: got %0d want 16", low); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL to_bus_err_pulses: got %0d want 1", pulses); end
    checks++; if (err_out !== 32'h0) begin errors++; $display("FAIL to_out: got %h want 0", err_out); end
    checks++; if (err_stall !== 1'b0) begin errors++; $display("FAIL to_stall_done: got %b want 0", err_stall); end
    checks++; if ({as_, stall} !== 2'b10) begin errors++; $display("FAIL to_idle: got as_,stall=%b want 10", {as_, stall}); end
    idle_in();
  endtask

  task automatic test_reset_access();
    int errs_seen = 0;
    ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h10; rdy_ = 1'b1;
    step();
    ex_en = 1'b0;
    step();
    checks++; if (as_ !== 1'b0) begin errors++; $display("FAIL rst_pre_as: got %b want 0", as_); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (as_ !== 1'b1) begin errors++; $display("FAIL rst_as: got %b want 1", as_); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    for (int i = 0; i < 3; i++) begin
      if (bus_err !== 1'b0 || as_ !== 1'b1) errs_seen++;
      step();
    end
    checks++; if (errs_seen !== 0) begin errors++; $display("FAIL rst_quiet: got %0d bad cycles want 0", errs_seen); end
    ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h10; rd_data = 32'hCAFE_F00D; rdy_ = 1'b0;
    step();
    ex_en = 1'b0;
    checks++; if ({as_, addr} !== {1'b0, 30'h4}) begin errors++; $display("FAIL rst_ldw_issue: got as_=%b addr=%h want 0/4", as_, addr); end
    step();
    checks++; if (out !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_ldw_out: got %h want cafef00d", out); end
    idle_in(); step();
  endtask

  task automatic test_nonmem();
    ex_en = 1'b1; ex_mem_op = 4'd0; ex_out = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nm_stall: got %b want 0", stall); end
    step();
    checks++; if ({as_, out} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL nm_out: got as_=%b out=%h want 1/deadbeef", as_, out); end
    ex_mem_op = 4'd12; ex_out = 32'h0BAD_F00D;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nm_op12_stall: got %b want 0", stall); end
    step();
    checks++; if ({as_, out} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL nm_op12_out: got as_=%b out=%h want 1/0badf00d", as_, out); end
    ex_en = 1'b0;
    step();
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL nm_disabled_out: got %h want 0", out); end
  endtask

  task automatic test_lanes();
    logic [3:0]  t_op [5] = '{4'd2, 4'd5, 4'd8, 4'd6, 4'd1};
    logic [31:0] t_ea [5] = '{32'h2, 32'h1, 32'h3, 32'h8, 32'h4};
    logic [31:0] t_wd [5] = '{32'h0, 32'h0, 32'h0000_005A, 32'h0123_4567, 32'h0};
    logic [31:0] t_rd [5] = '{32'h8001_0000, 32'h0000_F000, 32'h0, 32'h0, 32'h89AB_CDEF};
    logic [3:0]  e_be [5] = '{4'hF, 4'hF, 4'b1000, 4'hF, 4'hF};
    logic [31:0] e_bw [5] = '{32'h0, 32'h0, 32'h5A5A_5A5A, 32'h0123_4567, 32'h0};
    logic [31:0] e_out[5] = '{32'hFFFF_8001, 32'h0000_00F0, 32'h0, 32'h0, 32'h89AB_CDEF};
    logic        e_rw [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      ex_en = 1'b1; ex_mem_op = t_op[i]; ex_out = t_ea[i];
      ex_mem_wr_data = t_wd[i]; rd_data = t_rd[i]; rdy_ = 1'b0;
      step();
      ex_en = 1'b0;
      checks++; if (byte_en !== e_be[i]) begin errors++; $display("FAIL lane%0d_byte_en: got %h want %h", i, byte_en, e_be[i]); end
      checks++; if (rw !== e_rw[i]) begin errors++; $display("FAIL lane%0d_rw: got %b want %b", i, rw, e_rw[i]); end
      checks++; if (addr !== t_ea[i][31:2]) begin errors++; $display("FAIL lane%0d_addr: got %h want %h", i, addr, t_ea[i][31:2]); end
      if (e_rw[i] == 1'b0) begin
        checks++; if (wr_data !== e_bw[i]) begin errors++; $display("FAIL lane%0d_wr_data: got %h want %h", i, wr_data, e_bw[i]); end
      end
      step();
      checks++; if (out !== e_out[i]) begin errors++; $display("FAIL lane%0d_out: got %h want %h", i, out, e_out[i]); end
      idle_in(); step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_in();
    test_reset();
    test_ldb();
    test_sth_wait();
    test_misalign();
    test_timeout();
    test_reset_access();
    test_nonmem();
    test_lanes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, data width; legal values 32 or 64.
- BE_W, DATA_W/8, byte lanes, derived.
- OFS_W, log2(BE_W), byte-offset bits.
- TIMEOUT, 16, maximum rdy_-high cycles in ACCESS before abort; minimum 2.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- ex_en  in  1  EX/MEM entry valid.
- ex_mem_op  in  4  NOP=0 LDW=1 LDH=2 LDHU=3 LDB=4 LDBU=5 STW=6 STH=7 STB=8; 9-15 treated as NOP.
- ex_mem_wr_data  in  DATA_W  store data, right-aligned.
- ex_out  in  DATA_W  ALU result / byte address.
- rd_data  in  DATA_W  bus read data.
- rdy_  in  1  bus ready, active-low.
- addr  out  DATA_W-OFS_W  word address.
- as_  out  1  address strobe, active-low.
- rw  out  1  READ=1, WRITE=0.
- wr_data  out  DATA_W  lane-replicated store data.
- byte_en  out  BE_W  lane enables, bit i = byte lane i.
- out  out  DATA_W  registered MEM result.
- stall  out  1  pipeline hold request.
- miss_align  out  1  one-cycle pulse.
- bus_err  out  1  one-cycle pulse on timeout.

Function
REQ-003 States SHALL be IDLE, ACCESS and DONE. All bus outputs SHALL be registered.
REQ-004 Little-endian lane order SHALL apply: byte at offset k sits on lane k.
REQ-005 Alignment rules SHALL be:
- word ops: ex_out[OFS_W-1:0]==0.
- half ops: ex_out[0]==0.
- byte ops: always aligned.
REQ-006 IDLE, ex_en=1, aligned memory op: the next edge SHALL enter ACCESS and register the bus outputs:
- as_=0; addr=ex_out[DATA_W-1:OFS_W].
- rw from op.
- byte_en: all ones for loads; selected lanes for stores.
- wr_data: byte replicated on all lanes (STB); half replicated on half-lanes (STH); full word (STW).
REQ-007 IDLE, ex_en=1, misaligned memory op: no bus access SHALL occur; next edge sets out=0 and miss_align=1 for one cycle; stall stays 0.
REQ-008 IDLE, non-memory op or ex_en=0: next edge SHALL set out=ex_out when ex_en=1, otherwise out=0; stall=0.
REQ-009 stall SHALL be combinational and equal 1 in IDLE while accepting an aligned memory op, and 1 throughout ACCESS; it SHALL be 0 in DONE.
REQ-010 ACCESS, rdy_=0: next edge SHALL set as_=1, byte_en=0 and state DONE. For loads, out SHALL take the extracted rd_data lane: LDH and LDB sign-extended, LDHU and LDBU zero-extended, LDW unchanged. For stores, out=0.
REQ-011 ACCESS, rdy_=1: a wait counter SHALL increment. When it reaches TIMEOUT-1, the next edge SHALL set as_=1, out=0, bus_err=1 for one cycle, and state DONE.
REQ-012 DONE SHALL last exactly one cycle, SHALL return unconditionally to IDLE, and SHALL ignore ex_en. Minimum memory-op latency is therefore 3 cycles (accept, ACCESS with rdy_=0, DONE).
REQ-013 rdy_ SHALL be ignored outside ACCESS. The wait counter SHALL clear on entry to ACCESS.

Reset
REQ-014 On reset the block SHALL enter IDLE with: as_=1, rw=READ, addr=0, wr_data=0, byte_en=0, out=0, miss_align=0, bus_err=0, counter=0.
REQ-015 Reset during ACCESS SHALL abandon the transfer and drive as_=1 at the same edge; no bus_err SHALL be raised.

Structure
REQ-016 Package mem_access_pkg SHALL hold: op encodings, state encoding, READ/WRITE constants, ENABLE/DISABLE constants, active-low strobe constants.
REQ-017 Sub-module mem_lane_align (combinational) SHALL compute alignment check, byte_en, store replication and load extraction; the FSM, counter and registers SHALL stay in mem_access_unit.

Verification
REQ-018 The bench SHALL cover these directed scenarios (DATA_W=32):
- LDB at ex_out=0x103, rd_data=0x80FF_FF12 (byte lane 3 = 0x80), rdy_=0 in first ACCESS cycle -> as_=0 for one cycle, out=0xFFFF_FF80, stall high exactly 2 cycles.
- STH at ex_out=0x202, ex_mem_wr_data=0x1234_ABCD, rdy_ low after 3 waits -> addr=0x80, rw=0, byte_en=4'b1100, wr_data=0xABCD_ABCD, out=0.
- LDW at ex_out=0x6 -> miss_align pulse, as_ never low, out=0, stall=0.
- LDHU with rdy_ held high, TIMEOUT=16 -> as_ low for 16 cycles, then bus_err pulse, out=0, return to IDLE.
- reset asserted during ACCESS wait cycle 2 -> as_=1 next edge, IDLE, no bus_err; next LDW at 0x10 completes normally.
- non-memory op, ex_out=0xDEAD_BEEF -> out=0xDEAD_BEEF one cycle later, as_=1, stall=0.
